// File: rtl/sram_zbt_responder.sv
// Arbiter-facing request port onto a pipelined (ZBT) SRAM: registered pin commands,
// cycle-exact DQ ownership and fixed-latency, in-order read return.
module sram_zbt_responder #(
   parameter int unsigned ADDR_W      = 18,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned PIN_LATENCY = 1,
   parameter int unsigned INIT_CYCLES = 16
) (
   input  logic                  sram_clock,
   input  logic                  reset,
   input  logic                  sram_addr_valid,
   output logic                  sram_ready,
   input  logic [ADDR_W-1:0]     sram_addr,
   input  logic [DATA_W-1:0]     sram_data_in,
   input  logic [DATA_W/8-1:0]   sram_write_mask,
   output logic [DATA_W-1:0]     sram_data_out,
   output logic                  sram_data_out_valid,
   output logic [ADDR_W-1:0]     sram_a,
   output logic                  sram_ce_n,
   output logic                  sram_we_n,
   output logic [DATA_W/8-1:0]   sram_bw_n,
   output logic [DATA_W-1:0]     sram_dq_o,
   output logic                  sram_dq_oe,
   input  logic [DATA_W-1:0]     sram_dq_i
);

   localparam int unsigned MASK_W = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(INIT_CYCLES + 1);

   typedef enum logic [0:0] {StInit, StRun} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   init_cnt_q;

   logic               accept;
   logic               is_write;

   // Tag pipeline: stage k holds the command accepted k+1 cycles ago.
   logic [PIN_LATENCY-1:0] wr_tag_q;
   logic [PIN_LATENCY-1:0] rd_tag_q;
   logic [DATA_W-1:0]      wr_data_q [PIN_LATENCY];
   logic                   ret_q;

   assign accept   = sram_addr_valid && sram_ready;
   assign is_write = |sram_write_mask;

   always_ff @(posedge sram_clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StInit;
         init_cnt_q <= '0;
         sram_ready <= 1'b0;
      end else begin
         case (state_q)
            StInit: begin
               if (init_cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                  state_q    <= StRun;
                  sram_ready <= 1'b1;
               end else begin
                  init_cnt_q <= init_cnt_q + 1'b1;
               end
            end
            StRun: begin
               sram_ready <= 1'b1;
            end
            default: begin
               state_q    <= StInit;
               sram_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge sram_clock or negedge reset) begin
      if (!reset) begin
         sram_ce_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_bw_n <= {MASK_W{1'b1}};
         sram_a    <= '0;
      end else begin
         sram_ce_n <= !accept;
         sram_we_n <= !(accept && is_write);
         sram_bw_n <= (accept && is_write) ? ~sram_write_mask : {MASK_W{1'b1}};
         if (accept) begin
            sram_a <= sram_addr;
         end
      end
   end

   always_ff @(posedge sram_clock or negedge reset) begin
      if (!reset) begin
         wr_tag_q <= '0;
         rd_tag_q <= '0;
         for (int unsigned i = 0; i < PIN_LATENCY; i++) begin
            wr_data_q[i] <= '0;
         end
      end else begin
         wr_tag_q[0]  <= accept && is_write;
         rd_tag_q[0]  <= accept && !is_write;
         wr_data_q[0] <= sram_data_in;
         for (int unsigned i = 1; i < PIN_LATENCY; i++) begin
            wr_tag_q[i]  <= wr_tag_q[i-1];
            rd_tag_q[i]  <= rd_tag_q[i-1];
            wr_data_q[i] <= wr_data_q[i-1];
         end
      end
   end

   // Writes own DQ one cycle after the last tag stage; reads sample DQ in that same slot.
   always_ff @(posedge sram_clock or negedge reset) begin
      if (!reset) begin
         sram_dq_oe          <= 1'b0;
         sram_dq_o           <= '0;
         ret_q               <= 1'b0;
         sram_data_out_valid <= 1'b0;
         sram_data_out       <= '0;
      end else begin
         sram_dq_oe <= wr_tag_q[PIN_LATENCY-1];
         if (wr_tag_q[PIN_LATENCY-1]) begin
            sram_dq_o <= wr_data_q[PIN_LATENCY-1];
         end
         ret_q               <= rd_tag_q[PIN_LATENCY-1];
         sram_data_out_valid <= ret_q;
         if (ret_q) begin
            sram_data_out <= sram_dq_i;
         end
      end
   end

endmodule

// File: tb/tb_sram_zbt_responder.sv
// Bench for sram_zbt_responder: behavioural SRAM on the pins, a byte-merging memory
// model that predicts pin commands, DQ writes and read returns by cycle.
module tb_sram_zbt_responder;

   localparam int PL   = 1;
   localparam int AW   = 18;
   localparam int DW   = 32;
   localparam int MW   = DW / 8;
   localparam int INIT = 16;

   logic           sram_clock = 1'b0;
   logic           reset;
   logic           sram_addr_valid = 1'b0;
   logic           sram_ready;
   logic [AW-1:0]  sram_addr = '0;
   logic [DW-1:0]  sram_data_in = '0;
   logic [MW-1:0]  sram_write_mask = '0;
   logic [DW-1:0]  sram_data_out;
   logic           sram_data_out_valid;
   logic [AW-1:0]  sram_a;
   logic           sram_ce_n;
   logic           sram_we_n;
   logic [MW-1:0]  sram_bw_n;
   logic [DW-1:0]  sram_dq_o;
   logic           sram_dq_oe;
   logic [DW-1:0]  sram_dq_i = '0;

   sram_zbt_responder #(
      .ADDR_W(AW), .DATA_W(DW), .PIN_LATENCY(PL), .INIT_CYCLES(INIT)
   ) dut (
      .sram_clock(sram_clock), .reset(reset),
      .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready),
      .sram_addr(sram_addr), .sram_data_in(sram_data_in),
      .sram_write_mask(sram_write_mask), .sram_data_out(sram_data_out),
      .sram_data_out_valid(sram_data_out_valid), .sram_a(sram_a),
      .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_bw_n(sram_bw_n),
      .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
   );

   always #5 sram_clock = ~sram_clock;

   int cyc = 0;
   always @(posedge sram_clock) cyc <= cyc + 1;

   typedef struct {int cyc; logic [AW-1:0] a; logic we_n; logic [MW-1:0] bw_n;} cmd_t;
   typedef struct {int cyc; logic [DW-1:0] d;} ev_t;
   typedef struct {int due; logic [AW-1:0] a; logic [MW-1:0] bw_n;} pend_t;

   cmd_t obs_cmd[$], exp_cmd[$];
   ev_t  obs_dq[$], exp_dq[$], obs_rd[$], exp_rd[$];
   pend_t pend_wr[$], pend_rd[$];
   logic [DW-1:0] sram_mem [int];
   logic [DW-1:0] ref_mem [int];
   int conflicts = 0;
   int n_cmp = 0;
   int n_fail = 0;

   function automatic cmd_t mk_cmd(int c, logic [AW-1:0] a, logic we_n, logic [MW-1:0] bw_n);
      cmd_t r;
      r.cyc = c; r.a = a; r.we_n = we_n; r.bw_n = bw_n;
      return r;
   endfunction

   function automatic ev_t mk_ev(int c, logic [DW-1:0] d);
      ev_t r;
      r.cyc = c; r.d = d;
      return r;
   endfunction

   function automatic pend_t mk_pend(int due, logic [AW-1:0] a, logic [MW-1:0] bw_n);
      pend_t r;
      r.due = due; r.a = a; r.bw_n = bw_n;
      return r;
   endfunction

   // Pin monitor plus the external SRAM: sees commands, owns DQ reads, applies DQ writes.
   always @(negedge sram_clock) begin
      pend_t p;
      logic [DW-1:0] w;
      if (!sram_ce_n) obs_cmd.push_back(mk_cmd(cyc, sram_a, sram_we_n, sram_bw_n));
      if (sram_dq_oe) obs_dq.push_back(mk_ev(cyc, sram_dq_o));
      if (sram_data_out_valid) obs_rd.push_back(mk_ev(cyc, sram_data_out));
      while (pend_wr.size() > 0 && pend_wr[0].due <= cyc) begin
         p = pend_wr.pop_front();
         if (p.due == cyc && sram_dq_oe) begin
            w = sram_mem.exists(int'(p.a)) ? sram_mem[int'(p.a)] : '0;
            for (int i = 0; i < MW; i++) if (!p.bw_n[i]) w[8*i +: 8] = sram_dq_o[8*i +: 8];
            sram_mem[int'(p.a)] = w;
         end
      end
      while (pend_rd.size() > 0 && pend_rd[0].due < cyc) void'(pend_rd.pop_front());
      if (pend_rd.size() > 0 && pend_rd[0].due == cyc) begin
         p = pend_rd.pop_front();
         if (sram_dq_oe) conflicts++;
         sram_dq_i <= sram_mem.exists(int'(p.a)) ? sram_mem[int'(p.a)] : '0;
      end else begin
         sram_dq_i <= $urandom();
      end
      if (!sram_ce_n) begin
         if (!sram_we_n) pend_wr.push_back(mk_pend(cyc + PL, sram_a, sram_bw_n));
         else pend_rd.push_back(mk_pend(cyc + PL, sram_a, '1));
      end
   end

   task automatic clear_obs();
      obs_cmd.delete(); exp_cmd.delete(); obs_dq.delete(); exp_dq.delete();
      obs_rd.delete(); exp_rd.delete(); conflicts = 0;
   endtask

   // Drives one cycle of request inputs and records what the accepted request must produce.
   task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m);
      logic [DW-1:0] w;
      sram_addr_valid = v; sram_addr = a; sram_data_in = d; sram_write_mask = m;
      if (v) begin
         w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
         if (m != '0) begin
            exp_cmd.push_back(mk_cmd(cyc + 1, a, 1'b0, ~m));
            exp_dq.push_back(mk_ev(cyc + 1 + PL, d));
            for (int i = 0; i < MW; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
            ref_mem[int'(a)] = w;
         end else begin
            exp_cmd.push_back(mk_cmd(cyc + 1, a, 1'b1, '1));
            exp_rd.push_back(mk_ev(cyc + 2 + PL, w));
         end
      end
      @(negedge sram_clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, AW'($urandom()), $urandom(), MW'($urandom()));
   endtask

   // Releases reset and measures how long ready stays low and whether pins leave reset values.
   task automatic release_and_count(output int low, output int pin_bad);
      low = 0; pin_bad = 0;
      reset = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (sram_ready) break;
         if ({sram_ce_n, sram_we_n, sram_bw_n, sram_a, sram_dq_o, sram_dq_oe,
              sram_data_out_valid, sram_data_out} !== {1'b1, 1'b1, {MW{1'b1}}, {AW{1'b0}},
              {DW{1'b0}}, 1'b0, 1'b0, {DW{1'b0}}}) pin_bad++;
         low++;
         @(negedge sram_clock);
      end
   endtask

   task automatic test_reset();
      int low, bad, bad_rst;
      bad_rst = 0;
      reset = 1'b0;
      sram_addr_valid = 1'b1; sram_addr = 18'h00123; sram_write_mask = 4'hF;
      sram_data_in = 32'h12345678;
      for (int k = 0; k < 5; k++) begin
         @(negedge sram_clock);
         if ({sram_ready, sram_ce_n, sram_we_n, sram_bw_n, sram_a, sram_dq_o, sram_dq_oe,
              sram_data_out_valid, sram_data_out} !== {1'b0, 1'b1, 1'b1, {MW{1'b1}},
              {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0, {DW{1'b0}}}) bad_rst++;
      end
      n_cmp++;
      if (bad_rst != 0) begin
         n_fail++; $display("FAIL reset_pins: %0d bad cycles, want 0", bad_rst);
      end
      clear_obs();
      release_and_count(low, bad);
      sram_addr_valid = 1'b0;
      n_cmp++;
      if (low != INIT) begin
         n_fail++; $display("FAIL init_ready_low: got %0d cycles, want %0d", low, INIT);
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++; $display("FAIL init_pins: %0d bad cycles, want 0", bad);
      end
      n_cmp++;
      if (sram_ready !== 1'b1) begin
         n_fail++; $display("FAIL run_ready: got %b want 1", sram_ready);
      end
      idle(4);
      n_cmp++;
      if (obs_cmd.size() != 0) begin
         n_fail++; $display("FAIL init_no_accept: got %0d commands want 0", obs_cmd.size());
      end
   endtask

   task automatic test_write_read();
      int n;
      clear_obs();
      n = cyc;
      step(1'b1, 18'h00010, 32'hDEADBEEF, 4'hF);
      idle(6);
      n_cmp++;
      if (obs_cmd.size() != 1) begin
         n_fail++; $display("FAIL write_cmd_count: got %0d want 1", obs_cmd.size());
      end else begin
         n_cmp++;
         if ({obs_cmd[0].cyc, obs_cmd[0].a, obs_cmd[0].we_n, obs_cmd[0].bw_n} !==
             {n + 1, 18'h00010, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL write_cmd: got cyc=%0d a=%h we_n=%b bw_n=%h want cyc=%0d a=10 we_n=0 bw_n=0",
                     obs_cmd[0].cyc - n, obs_cmd[0].a, obs_cmd[0].we_n, obs_cmd[0].bw_n, 1);
         end
      end
      n_cmp++;
      if (obs_dq.size() != 1 || obs_dq[0].cyc != n + 2 || obs_dq[0].d !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL write_dq: got %0d oe cycles, want one at +2 with deadbeef",
                            obs_dq.size());
      end
      n_cmp++;
      if (obs_rd.size() != 0) begin
         n_fail++; $display("FAIL write_no_valid: got %0d pulses want 0", obs_rd.size());
      end
      clear_obs();
      n = cyc;
      step(1'b1, 18'h00010, $urandom(), 4'h0);
      idle(6);
      n_cmp++;
      if (obs_rd.size() != 1) begin
         n_fail++; $display("FAIL read_count: got %0d pulses want 1", obs_rd.size());
      end else begin
         n_cmp++;
         if (obs_rd[0].cyc != n + 3 || obs_rd[0].d !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_data: got +%0d %h want +3 deadbeef",
                               obs_rd[0].cyc - n, obs_rd[0].d);
         end
      end
      n_cmp++;
      if (obs_dq.size() != 0) begin
         n_fail++; $display("FAIL read_no_oe: got %0d oe cycles want 0", obs_dq.size());
      end
   endtask

   task automatic test_partial();
      int n;
      clear_obs();
      step(1'b1, 18'h00030, 32'hAAAAAAAA, 4'hF);
      n = cyc;
      step(1'b1, 18'h00030, 32'h11223344, 4'b0101);
      step(1'b1, 18'h00030, $urandom(), 4'h0);
      idle(6);
      n_cmp++;
      if (obs_cmd.size() != 3 || obs_cmd[1].bw_n !== 4'b1010) begin
         n_fail++; $display("FAIL partial_bw_n: got %0d cmds, bw_n=%b want 3 cmds, 1010",
                            obs_cmd.size(), (obs_cmd.size() > 1) ? obs_cmd[1].bw_n : 4'hx);
      end
      n_cmp++;
      if (obs_rd.size() != 1 || obs_rd[0].d !== 32'hAA22AA44 || obs_rd[0].cyc != n + 4) begin
         n_fail++; $display("FAIL partial_read: got %0d pulses data=%h want 1 pulse aa22aa44",
                            obs_rd.size(), (obs_rd.size() > 0) ? obs_rd[0].d : 32'hx);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat;
      pat = 8'b00100101;
      clear_obs();
      for (int i = 0; i < 8; i++)
         step(1'b1, (i % 2 == 1) ? 18'h00021 : 18'h00020, $urandom(), pat[i] ? 4'hF : 4'h0);
      idle(6);
      n_cmp++;
      if (obs_cmd.size() != 8 || obs_rd.size() != 5 || obs_dq.size() != 3) begin
         n_fail++; $display("FAIL stream_counts: got cmd=%0d rd=%0d dq=%0d want 8 5 3",
                            obs_cmd.size(), obs_rd.size(), obs_dq.size());
      end
      for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++) begin
         n_cmp++;
         if ({obs_cmd[i].cyc, obs_cmd[i].a, obs_cmd[i].we_n, obs_cmd[i].bw_n} !==
             {exp_cmd[i].cyc, exp_cmd[i].a, exp_cmd[i].we_n, exp_cmd[i].bw_n}) begin
            n_fail++; $display("FAIL stream_cmd[%0d]: got cyc=%0d a=%h we_n=%b want cyc=%0d a=%h we_n=%b",
                               i, obs_cmd[i].cyc, obs_cmd[i].a, obs_cmd[i].we_n,
                               exp_cmd[i].cyc, exp_cmd[i].a, exp_cmd[i].we_n);
         end
      end
      for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
         n_cmp++;
         if (obs_rd[i].cyc != exp_rd[i].cyc || obs_rd[i].d !== exp_rd[i].d) begin
            n_fail++; $display("FAIL stream_rd[%0d]: got cyc=%0d %h want cyc=%0d %h", i,
                               obs_rd[i].cyc, obs_rd[i].d, exp_rd[i].cyc, exp_rd[i].d);
         end
      end
      n_cmp++;
      if (conflicts != 0) begin
         n_fail++; $display("FAIL stream_turnaround: got %0d dq clashes want 0", conflicts);
      end
   endtask

   task automatic test_random();
      logic w;
      clear_obs();
      for (int i = 0; i < 300; i++) begin
         w = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0)
            step(1'b1, AW'($urandom_range(0, 7)), $urandom(), w ? MW'($urandom_range(1, 15)) : '0);
         else
            step(1'b0, AW'($urandom()), $urandom(), MW'($urandom()));
      end
      idle(8);
      n_cmp++;
      if (obs_cmd.size() != exp_cmd.size() || obs_dq.size() != exp_dq.size() ||
          obs_rd.size() != exp_rd.size()) begin
         n_fail++; $display("FAIL random_counts: got cmd=%0d dq=%0d rd=%0d want %0d %0d %0d",
                            obs_cmd.size(), obs_dq.size(), obs_rd.size(),
                            exp_cmd.size(), exp_dq.size(), exp_rd.size());
      end
      for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++) begin
         n_cmp++;
         if ({obs_cmd[i].cyc, obs_cmd[i].a, obs_cmd[i].we_n, obs_cmd[i].bw_n} !==
             {exp_cmd[i].cyc, exp_cmd[i].a, exp_cmd[i].we_n, exp_cmd[i].bw_n}) begin
            n_fail++; $display("FAIL random_cmd[%0d]: got cyc=%0d a=%h bw_n=%b want cyc=%0d a=%h bw_n=%b",
                               i, obs_cmd[i].cyc, obs_cmd[i].a, obs_cmd[i].bw_n,
                               exp_cmd[i].cyc, exp_cmd[i].a, exp_cmd[i].bw_n);
         end
      end
      for (int i = 0; i < exp_dq.size() && i < obs_dq.size(); i++) begin
         n_cmp++;
         if (obs_dq[i].cyc != exp_dq[i].cyc || obs_dq[i].d !== exp_dq[i].d) begin
            n_fail++; $display("FAIL random_dq[%0d]: got cyc=%0d %h want cyc=%0d %h", i,
                               obs_dq[i].cyc, obs_dq[i].d, exp_dq[i].cyc, exp_dq[i].d);
         end
      end
      for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++) begin
         n_cmp++;
         if (obs_rd[i].cyc != exp_rd[i].cyc || obs_rd[i].d !== exp_rd[i].d) begin
            n_fail++; $display("FAIL random_rd[%0d]: got cyc=%0d %h want cyc=%0d %h", i,
                               obs_rd[i].cyc, obs_rd[i].d, exp_rd[i].cyc, exp_rd[i].d);
         end
      end
      n_cmp++;
      if (conflicts != 0) begin
         n_fail++; $display("FAIL random_turnaround: got %0d dq clashes want 0", conflicts);
      end
   endtask

   task automatic test_reset_midflight();
      int low, bad;
      clear_obs();
      step(1'b1, 18'h3FFFF, $urandom(), 4'hF);
      idle(1);
      n_cmp++;
      if (sram_dq_oe !== 1'b1) begin
         n_fail++; $display("FAIL mid_oe_before: got %b want 1", sram_dq_oe);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (sram_dq_oe !== 1'b0 || sram_ce_n !== 1'b1) begin
         n_fail++; $display("FAIL mid_oe_release: got oe=%b ce_n=%b want 0 1", sram_dq_oe, sram_ce_n);
      end
      @(negedge sram_clock);
      pend_wr.delete(); pend_rd.delete();
      release_and_count(low, bad);
      clear_obs();
      step(1'b1, 18'h00005, $urandom(), 4'h0);
      step(1'b1, 18'h00006, $urandom(), 4'h0);
      sram_addr_valid = 1'b0;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (sram_data_out_valid !== 1'b0 || sram_ready !== 1'b0 || sram_dq_oe !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_outputs: got valid=%b ready=%b oe=%b want 0 0 0",
                            sram_data_out_valid, sram_ready, sram_dq_oe);
      end
      @(negedge sram_clock);
      @(negedge sram_clock);
      pend_wr.delete(); pend_rd.delete();
      release_and_count(low, bad);
      n_cmp++;
      if (low != INIT) begin
         n_fail++; $display("FAIL mid_init_low: got %0d cycles want %0d", low, INIT);
      end
      idle(6);
      n_cmp++;
      if (obs_rd.size() != 0) begin
         n_fail++; $display("FAIL mid_no_valid: got %0d pulses want 0", obs_rd.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_partial();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
